// File: rtl/spi_regbank.sv
// SPI slave register bank: NUM_STAT status and NUM_CTRL control registers, with burst auto-increment.
// Latency: a write lands on the rising edge that samples its last bit; read data is driven from the falling edge after the op bit or previous word.
// Backpressure: none; the SPI master owns sclk, and dropping cs discards any partial word.
module spi_regbank #(
    parameter int ADDR_BITS = 4,
    parameter int DATA_BITS = 8,
    parameter int NUM_STAT  = 2,
    parameter int NUM_CTRL  = 4,
    parameter int BURST     = 1,
    parameter logic [NUM_CTRL*DATA_BITS-1:0] CTRL_RST = '0
) (
    input  logic                          sclk,
    input  logic                          reset,
    input  logic                          cs,
    input  logic                          din,
    output logic                          dout,
    output logic                          dout_en,
    output logic [NUM_CTRL*DATA_BITS-1:0] ctrl,
    output logic [NUM_CTRL-1:0]           ctrl_wr_tgl,
    input  logic [NUM_STAT*DATA_BITS-1:0] stat
);

    localparam int HW = $clog2(ADDR_BITS + 2);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [HW-1:0] HDR_LAST = HW'(ADDR_BITS + 1);
    localparam logic [HW-1:0] ADDR_END = HW'(ADDR_BITS);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    logic                 blocked;
    logic                 frame_clr;
    logic [HW-1:0]        hdr_cnt;
    logic [ADDR_BITS-1:0] addr;
    logic                 op;
    logic [BW-1:0]        bit_cnt;
    logic [ADDR_BITS-1:0] word_cnt;
    logic                 more;
    logic [DATA_BITS-2:0] rx;
    logic [DATA_BITS-1:0] tx;
    logic                 en_flag;

    logic                 hdr_done;
    logic [ADDR_BITS-1:0] target;
    logic                 word_live;
    logic                 wr_strobe;
    logic [DATA_BITS-1:0] wr_word;
    logic [DATA_BITS-1:0] rd_word;

    // A reset that arrives while cs is high blocks the frame until cs falls, so the frame cannot resume mid-stream
    always_ff @(posedge reset or negedge cs) begin
        if (reset) blocked <= cs;
        else       blocked <= 1'b0;
    end

    assign frame_clr = reset | ~cs | blocked;
    assign hdr_done  = (hdr_cnt == HDR_LAST);
    assign target    = addr + word_cnt;
    assign word_live = (BURST != 0) || !more;
    assign wr_word   = {din, rx};
    assign wr_strobe = cs & hdr_done & op & (bit_cnt == BIT_LAST) & word_live;

    // Read source select for the current word; unmapped or suppressed words read as zero
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_STAT; i++)
            if (int'(target) == i) rd_word = stat[i*DATA_BITS +: DATA_BITS];
        for (int i = 0; i < NUM_CTRL; i++)
            if (int'(target) == NUM_STAT + i) rd_word = ctrl[i*DATA_BITS +: DATA_BITS];
        if (!word_live) rd_word = '0;
    end

    // Rising-edge frame sequencer: address and op header, then wrapping in-word bit count and word count
    always_ff @(posedge sclk or posedge frame_clr) begin
        if (frame_clr) begin
            hdr_cnt  <= '0;
            addr     <= '0;
            op       <= 1'b0;
            bit_cnt  <= '0;
            word_cnt <= '0;
            more     <= 1'b0;
            rx       <= '0;
        end else if (!hdr_done) begin
            if (hdr_cnt < ADDR_END) addr <= {din, addr[ADDR_BITS-1:1]};
            else                    op   <= din;
            hdr_cnt <= hdr_cnt + 1'b1;
        end else begin
            for (int i = 0; i < DATA_BITS - 1; i++)
                if (int'(bit_cnt) == i) rx[i] <= din;
            if (bit_cnt == BIT_LAST) begin
                bit_cnt  <= '0;
                word_cnt <= word_cnt + 1'b1;
                more     <= 1'b1;
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    // Control registers survive cs toggling; only reset restores them
    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            ctrl        <= CTRL_RST;
            ctrl_wr_tgl <= '0;
        end else if (wr_strobe) begin
            for (int i = 0; i < NUM_CTRL; i++) begin
                if (int'(target) == NUM_STAT + i) begin
                    ctrl[i*DATA_BITS +: DATA_BITS] <= wr_word;
                    ctrl_wr_tgl[i]                 <= ~ctrl_wr_tgl[i];
                end
            end
        end
    end

    // Falling-edge transmitter: snapshot at each word boundary of a read frame, otherwise shift right
    always_ff @(negedge sclk or posedge frame_clr) begin
        if (frame_clr) begin
            tx      <= '0;
            en_flag <= 1'b0;
        end else if (hdr_done && !op && bit_cnt == '0) begin
            tx      <= rd_word;
            en_flag <= 1'b1;
        end else if (en_flag) begin
            tx <= {1'b0, tx[DATA_BITS-1:1]};
        end
    end

    assign dout    = tx[0] & en_flag;
    assign dout_en = cs & en_flag;

endmodule

// File: tb/tb_spi_regbank.sv
module tb_spi_regbank;

    logic        sclk, reset, cs, din;
    logic [15:0] stat;
    logic        dout1, en1, dout0, en0;
    logic [31:0] ctrl1, ctrl0;
    logic [3:0]  tgl1, tgl0;

    logic s_dout1, s_dout0, s_en1, s_en0;
    int   total  = 0;
    int   passed = 0;

    spi_regbank #(.ADDR_BITS(4), .DATA_BITS(8), .NUM_STAT(2), .NUM_CTRL(4), .BURST(1),
                  .CTRL_RST(32'h44332211)) u_burst (
        .sclk(sclk), .reset(reset), .cs(cs), .din(din), .dout(dout1), .dout_en(en1),
        .ctrl(ctrl1), .ctrl_wr_tgl(tgl1), .stat(stat));

    spi_regbank #(.ADDR_BITS(4), .DATA_BITS(8), .NUM_STAT(2), .NUM_CTRL(4), .BURST(0),
                  .CTRL_RST(32'h44332211)) u_single (
        .sclk(sclk), .reset(reset), .cs(cs), .din(din), .dout(dout0), .dout_en(en0),
        .ctrl(ctrl0), .ctrl_wr_tgl(tgl0), .stat(stat));

    typedef struct {
        logic [3:0]  a;
        logic        op;
        int          nbits;
        logic [23:0] wd;
        logic [31:0] c1;
        logic [3:0]  t1;
        logic [23:0] r1;
        logic [31:0] c0;
        logic [3:0]  t0;
        logic [23:0] r0;
    } vec_t;

    typedef struct {
        logic [31:0] c1;
        logic [3:0]  t1;
        logic [23:0] r1;
        logic [31:0] c0;
        logic [3:0]  t0;
        logic [23:0] r0;
    } exp_t;

    vec_t vt[9];
    exp_t sb[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // One SPI bit: set din while sclk is low, sample what the master would see, then pulse sclk
    task automatic clk_edge(input logic d);
        din = d;
        #2;
        s_dout1 = dout1; s_dout0 = dout0; s_en1 = en1; s_en0 = en0;
        sclk = 1'b1;
        #5;
        sclk = 1'b0;
        #3;
    endtask

    task automatic run_frame(input logic [3:0] a, input logic op, input int nbits, input logic [23:0] wd,
                             output logic [23:0] r1, output logic [23:0] r0, output logic en_ok);
        r1 = '0; r0 = '0; en_ok = 1'b1;
        cs = 1'b1;
        #5;
        for (int i = 0; i < 4; i++) begin
            clk_edge(a[i]);
            if (s_en1 || s_en0) en_ok = 1'b0;
        end
        clk_edge(op);
        if (s_en1 || s_en0) en_ok = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            clk_edge(op ? wd[i] : 1'($urandom_range(0, 1)));
            r1[i] = s_dout1;
            r0[i] = s_dout0;
            if (s_en1 !== !op || s_en0 !== !op) en_ok = 1'b0;
        end
        #2 cs = 1'b0;
        #5;
    endtask

    initial begin
        logic [23:0] r1, r0;
        logic        en_ok;
        logic [12:0] blk_bits;
        exp_t        e;

        vt[0] = '{4'd2,  1'b1, 8,  24'h0000A5, 32'h443322A5, 4'b0001, 24'h0,      32'h443322A5, 4'b0001, 24'h0};
        vt[1] = '{4'd3,  1'b1, 24, 24'h332211, 32'h332211A5, 4'b1111, 24'h0,      32'h443311A5, 4'b0011, 24'h0};
        vt[2] = '{4'd0,  1'b0, 8,  24'h0,      32'h332211A5, 4'b1111, 24'h00005A, 32'h443311A5, 4'b0011, 24'h00005A};
        vt[3] = '{4'd15, 1'b0, 24, 24'h0,      32'h332211A5, 4'b1111, 24'hC35A00, 32'h443311A5, 4'b0011, 24'h0};
        vt[4] = '{4'd4,  1'b0, 16, 24'h0,      32'h332211A5, 4'b1111, 24'h003322, 32'h443311A5, 4'b0011, 24'h000033};
        vt[5] = '{4'd2,  1'b1, 4,  24'h00000F, 32'h332211A5, 4'b1111, 24'h0,      32'h443311A5, 4'b0011, 24'h0};
        vt[6] = '{4'd2,  1'b1, 8,  24'h00003C, 32'h3322113C, 4'b1110, 24'h0,      32'h4433113C, 4'b0010, 24'h0};
        vt[7] = '{4'd1,  1'b1, 8,  24'h0000FF, 32'h3322113C, 4'b1110, 24'h0,      32'h4433113C, 4'b0010, 24'h0};
        vt[8] = '{4'd5,  1'b1, 16, 24'h008877, 32'h7722113C, 4'b0110, 24'h0,      32'h7733113C, 4'b1010, 24'h0};

        sclk = 1'b0; cs = 1'b0; din = 1'b0; stat = 16'hC35A;
        reset = 1'b1;
        #10;
        check("rst_ctrl_b", ctrl1, 32'h44332211);
        check("rst_tgl_b",  {28'd0, tgl1}, 32'h0);
        check("rst_en_b",   {31'd0, en1}, 32'h0);
        check("rst_dout_b", {31'd0, dout1}, 32'h0);
        check("rst_ctrl_s", ctrl0, 32'h44332211);
        check("rst_tgl_s",  {28'd0, tgl0}, 32'h0);
        check("rst_en_s",   {31'd0, en0}, 32'h0);
        reset = 1'b0;
        #10;

        for (int v = 0; v < 9; v++) begin
            sb.push_back('{vt[v].c1, vt[v].t1, vt[v].r1, vt[v].c0, vt[v].t0, vt[v].r0});
            run_frame(vt[v].a, vt[v].op, vt[v].nbits, vt[v].wd, r1, r0, en_ok);
            e = sb.pop_front();
            check($sformatf("vec%0d_ctrl_b", v), ctrl1, e.c1);
            check($sformatf("vec%0d_tgl_b", v),  {28'd0, tgl1}, {28'd0, e.t1});
            check($sformatf("vec%0d_rd_b", v),   {8'd0, r1}, {8'd0, e.r1});
            check($sformatf("vec%0d_ctrl_s", v), ctrl0, e.c0);
            check($sformatf("vec%0d_tgl_s", v),  {28'd0, tgl0}, {28'd0, e.t0});
            check($sformatf("vec%0d_rd_s", v),   {8'd0, r0}, {8'd0, e.r0});
            check($sformatf("vec%0d_en", v),     {31'd0, en_ok}, 32'h1);
            check($sformatf("vec%0d_en_idle", v), {30'd0, en1, en0}, 32'h0);
        end

        // Reset in the middle of a read frame
        cs = 1'b1;
        #5;
        for (int i = 0; i < 5; i++) clk_edge(1'b0);
        clk_edge(1'b0);
        clk_edge(1'b0);
        check("midrd_en", {31'd0, en1}, 32'h1);
        reset = 1'b1;
        #3;
        check("midrst_ctrl_b", ctrl1, 32'h44332211);
        check("midrst_tgl_b",  {28'd0, tgl1}, 32'h0);
        check("midrst_en_b",   {31'd0, en1}, 32'h0);
        check("midrst_dout_b", {31'd0, dout1}, 32'h0);
        check("midrst_ctrl_s", ctrl0, 32'h44332211);
        check("midrst_tgl_s",  {28'd0, tgl0}, 32'h0);
        #5;
        reset = 1'b0;
        #5;

        // cs held high across reset release: the stale frame must not act on these edges
        blk_bits = {8'h99, 1'b1, 4'd2};
        for (int i = 0; i < 13; i++) clk_edge(blk_bits[i]);
        check("blocked_ctrl", ctrl1, 32'h44332211);
        check("blocked_tgl",  {28'd0, tgl1}, 32'h0);
        #2 cs = 1'b0;
        #5;

        run_frame(4'd2, 1'b1, 8, 24'h00005C, r1, r0, en_ok);
        check("after_rst_ctrl_b", ctrl1, 32'h4433225C);
        check("after_rst_tgl_b",  {28'd0, tgl1}, 32'h1);
        check("after_rst_ctrl_s", ctrl0, 32'h4433225C);
        check("after_rst_tgl_s",  {28'd0, tgl0}, 32'h1);
        check("after_rst_en",     {31'd0, en_ok}, 32'h1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
